// File: rtl/mips_core_pkg.sv
// Shared core definitions: branch direction encoding and gshare predictor
// counter types/constants.
package mips_core_pkg;

  localparam logic TAKEN     = 1'b1;
  localparam logic NOT_TAKEN = 1'b0;

  typedef logic [1:0] bp_counter_t;

  // Counters come out of reset weakly not-taken so one taken outcome flips them.
  localparam bp_counter_t BP_CTR_RESET = 2'b01;
  localparam logic [31:0] BP_STAT_MAX  = 32'hFFFF_FFFF;

endpackage

// File: rtl/branch_predictor_gshare_if.sv
// Predict/update exchange between the branch controller (master) and the
// gshare predictor (slave), plus the predictor's performance counters.
interface branch_predictor_gshare_if #(
  parameter int GHR_BITS = 8
);

  logic                req_valid;
  logic [31:0]         req_pc;
  logic                pred_taken;
  logic [GHR_BITS-1:0] pred_ghr;

  logic                upd_valid;
  logic [31:0]         upd_pc;
  logic [GHR_BITS-1:0] upd_ghr;
  logic                upd_outcome;
  logic                upd_prediction;
  logic                ex_stall;

  logic [31:0]         stat_branches;
  logic [31:0]         stat_mispredicts;

  modport master (
    output req_valid, req_pc, upd_valid, upd_pc, upd_ghr, upd_outcome,
           upd_prediction, ex_stall,
    input  pred_taken, pred_ghr, stat_branches, stat_mispredicts
  );

  modport slave (
    input  req_valid, req_pc, upd_valid, upd_pc, upd_ghr, upd_outcome,
           upd_prediction, ex_stall,
    output pred_taken, pred_ghr, stat_branches, stat_mispredicts
  );

endinterface

// File: rtl/bp_sat_counter.sv
// Parameterised saturating up/down counter with a synchronous reset value;
// UP_ONLY turns it into a saturating event counter.
module bp_sat_counter #(
  parameter int               WIDTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               UP_ONLY   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= RESET_VAL;
    end else if (en) begin
      if (up || UP_ONLY) begin
        if (count != MAX_VAL) count <= count + WIDTH'(1);
      end else if (count != '0) begin
        count <= count - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare predictor: 2-bit counter table indexed by PC ^ GHR, non-speculative
// history updated at resolve, and saturating branch/mispredict statistics.
module branch_predictor_gshare
  import mips_core_pkg::*;
#(
  parameter int INDEX_BITS = 8,
  parameter int GHR_BITS   = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  branch_predictor_gshare_if.slave bp
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [GHR_BITS-1:0]   ghr_q;
  logic [INDEX_BITS-1:0] pred_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic                  upd_fire;
  logic                  upd_up;
  logic                  upd_miss;
  bp_counter_t           table_q [ENTRIES];

  assign upd_fire = bp.upd_valid & ~bp.ex_stall;
  assign upd_up   = (bp.upd_outcome == TAKEN);
  assign upd_miss = upd_fire && (bp.upd_prediction != bp.upd_outcome);

  assign pred_idx = bp.req_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
  assign upd_idx  = bp.upd_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(bp.upd_ghr);

  // Reads see only registered state, so a same-cycle update is never bypassed.
  assign bp.pred_taken = table_q[pred_idx][1] ? TAKEN : NOT_TAKEN;
  assign bp.pred_ghr   = ghr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (upd_fire) begin
      ghr_q <= {ghr_q[GHR_BITS-2:0], bp.upd_outcome};
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    bp_sat_counter #(
      .WIDTH     (2),
      .RESET_VAL (BP_CTR_RESET),
      .UP_ONLY   (1'b0)
    ) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (upd_fire && (upd_idx == INDEX_BITS'(i))),
      .up    (upd_up),
      .count (table_q[i])
    );
  end

  bp_sat_counter #(
    .WIDTH     (32),
    .RESET_VAL (32'd0),
    .UP_ONLY   (1'b1)
  ) u_stat_branches (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (upd_fire),
    .up    (1'b1),
    .count (bp.stat_branches)
  );

  bp_sat_counter #(
    .WIDTH     (32),
    .RESET_VAL (32'd0),
    .UP_ONLY   (1'b1)
  ) u_stat_mispredicts (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (upd_miss),
    .up    (1'b1),
    .count (bp.stat_mispredicts)
  );

  // req_valid and the PC bits outside the index only matter to checkers upstream.
  logic unused_bits;
  assign unused_bits = ^{bp.req_valid,
                         bp.req_pc[31:INDEX_BITS+2], bp.req_pc[1:0],
                         bp.upd_pc[31:INDEX_BITS+2], bp.upd_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed self-checking bench for branch_predictor_gshare: reset sweep,
// training, saturation, stall, same-cycle collision and reset-during-update.
module tb_branch_predictor_gshare;

  logic clk;
  logic rst_n;
  int   assert_count = 0;
  int   fail_count   = 0;

  branch_predictor_gshare_if #(.GHR_BITS(8)) bp ();

  branch_predictor_gshare #(
    .INDEX_BITS (8),
    .GHR_BITS   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One update pulse that is accepted at the next rising edge.
  task automatic applyStimulus(input logic [31:0] pc, input logic [7:0] ghr,
                               input logic outcome, input logic prediction);
    bp.upd_pc         = pc;
    bp.upd_ghr        = ghr;
    bp.upd_outcome    = outcome;
    bp.upd_prediction = prediction;
    bp.upd_valid      = 1'b1;
    @(posedge clk);
    #1;
    bp.upd_valid = 1'b0;
  endtask

  // Request PC whose index lands on table entry idx under history ghr.
  function automatic logic [31:0] pc_for(input logic [7:0] idx, input logic [7:0] ghr);
    logic [7:0] raw;
    raw = idx ^ ghr;
    return {22'd0, raw, 2'b00};
  endfunction

  // Reads entry 0x40 given the history the bench expects the DUT to hold.
  task automatic probe(input string tag, input logic [7:0] ghr, input logic exp_taken);
    bp.req_pc = pc_for(8'h40, ghr);
    #1;
    checkOutput(tag, {31'd0, bp.pred_taken}, {31'd0, exp_taken});
    checkOutput({tag, "_ghr"}, {24'd0, bp.pred_ghr}, {24'd0, ghr});
  endtask

  task automatic check_stats(input string tag, input logic [31:0] br, input logic [31:0] mp);
    checkOutput({tag, "_branches"}, bp.stat_branches, br);
    checkOutput({tag, "_mispredicts"}, bp.stat_mispredicts, mp);
  endtask

  logic       sat_taken [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [7:0] sat_ghr   [5] = '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0};

  initial begin
    rst_n             = 1'b0;
    bp.req_valid      = 1'b0;
    bp.req_pc         = '0;
    bp.upd_valid      = 1'b0;
    bp.upd_pc         = '0;
    bp.upd_ghr        = '0;
    bp.upd_outcome    = 1'b0;
    bp.upd_prediction = 1'b0;
    bp.ex_stall       = 1'b0;

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    bp.req_valid = 1'b1;
    for (int a = 0; a < 256; a++) begin
      bp.req_pc = 32'(a) << 2;
      #1;
      checkOutput("reset_sweep", {31'd0, bp.pred_taken}, 32'd0);
    end
    checkOutput("reset_ghr", {24'd0, bp.pred_ghr}, 32'd0);
    check_stats("reset", 32'd0, 32'd0);

    probe("train0", 8'h00, 1'b0);
    applyStimulus(32'h100, 8'h00, 1'b1, 1'b0);
    probe("train1", 8'h01, 1'b1);
    check_stats("train1", 32'd1, 32'd1);
    applyStimulus(32'h100, 8'h00, 1'b1, 1'b0);
    probe("train2", 8'h03, 1'b1);
    applyStimulus(32'h100, 8'h00, 1'b1, 1'b0);
    probe("train3", 8'h07, 1'b1);
    check_stats("train3", 32'd3, 32'd3);
    bp.req_pc = 32'h100;
    #1;
    checkOutput("idx47", {31'd0, bp.pred_taken}, 32'd0);

    for (int k = 0; k < 5; k++) begin
      applyStimulus(32'h100, 8'h00, 1'b0, 1'b0);
      probe($sformatf("sat%0d", k), sat_ghr[k], sat_taken[k]);
    end
    check_stats("sat", 32'd8, 32'd3);

    applyStimulus(32'h100, 8'h00, 1'b1, 1'b0);
    probe("unsat1", 8'hC1, 1'b0);
    applyStimulus(32'h100, 8'h00, 1'b1, 1'b0);
    probe("unsat2", 8'h83, 1'b1);
    check_stats("unsat", 32'd10, 32'd5);

    bp.upd_pc         = 32'h100;
    bp.upd_ghr        = 8'h00;
    bp.upd_outcome    = 1'b0;
    bp.upd_prediction = 1'b1;
    bp.ex_stall       = 1'b1;
    bp.upd_valid      = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      probe("stall_hold", 8'h83, 1'b1);
      checkOutput("stall_branches", bp.stat_branches, 32'd10);
    end
    bp.ex_stall = 1'b0;
    @(posedge clk);
    #1;
    bp.upd_valid = 1'b0;
    probe("stall_fire", 8'h06, 1'b0);
    check_stats("stall_fire", 32'd11, 32'd6);
    applyStimulus(32'h100, 8'h00, 1'b1, 1'b0);
    probe("post_stall", 8'h0D, 1'b1);
    check_stats("post_stall", 32'd12, 32'd7);

    bp.req_pc         = pc_for(8'h40, 8'h0D);
    bp.upd_pc         = 32'h100;
    bp.upd_ghr        = 8'h00;
    bp.upd_outcome    = 1'b0;
    bp.upd_prediction = 1'b0;
    bp.upd_valid      = 1'b1;
    #1;
    checkOutput("coll1_same", {31'd0, bp.pred_taken}, 32'd1);
    checkOutput("coll1_same_ghr", {24'd0, bp.pred_ghr}, 32'h0D);
    @(posedge clk);
    #1;
    bp.upd_valid = 1'b0;
    probe("coll1_next", 8'h1A, 1'b0);

    bp.req_pc         = pc_for(8'h40, 8'h1A);
    bp.upd_outcome    = 1'b1;
    bp.upd_prediction = 1'b0;
    bp.upd_valid      = 1'b1;
    #1;
    checkOutput("coll2_same", {31'd0, bp.pred_taken}, 32'd0);
    checkOutput("coll2_same_ghr", {24'd0, bp.pred_ghr}, 32'h1A);
    @(posedge clk);
    #1;
    bp.upd_valid = 1'b0;
    probe("coll2_next", 8'h35, 1'b1);
    check_stats("coll", 32'd14, 32'd8);

    rst_n             = 1'b0;
    bp.upd_pc         = 32'h100;
    bp.upd_ghr        = 8'h00;
    bp.upd_outcome    = 1'b1;
    bp.upd_prediction = 1'b0;
    bp.upd_valid      = 1'b1;
    @(posedge clk);
    #1;
    bp.upd_valid = 1'b0;
    probe("rst_hold", 8'h00, 1'b0);
    check_stats("rst_hold", 32'd0, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    probe("rst_release", 8'h00, 1'b0);
    check_stats("rst_release", 32'd0, 32'd0);

    applyStimulus(32'h100, 8'h00, 1'b1, 1'b1);
    probe("post_rst", 8'h01, 1'b1);
    check_stats("post_rst", 32'd1, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
